// File: rtl/aemb2_dpsram_port.sv
// Wishbone-classic slave driving one port of the dual-port SRAM.
// Absorbs the RAM read latency and zero-fills the array on request.
module aemb2_dpsram_port #(
    parameter int AW      = 5,
    parameter int DW      = 2,
    parameter bit CLR_RST = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    input  logic          clr_i,
    output logic          busy_o,
    output logic          ram_ena_o,
    output logic          ram_wre_o,
    output logic [AW-1:0] ram_adr_o,
    output logic [DW-1:0] ram_dat_o,
    input  logic [DW-1:0] ram_dat_i
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RWAIT,
        S_RDAT,
        S_ACK
    } state_t;

    localparam state_t RST_ST = CLR_RST ? S_CLEAR : S_IDLE;

    state_t        state_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          busy_q;
    logic          ack_q;
    logic          ena_q;
    logic          wre_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] wdat_q;
    logic [DW-1:0] rdat_q;

    // Extra top bit marks that every word has been issued.
    assign cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RST_ST;
            busy_q  <= CLR_RST;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            ena_q   <= 1'b0;
            wre_q   <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    if (cnt_q[AW]) begin
                        ena_q   <= 1'b0;
                        wre_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        ena_q  <= 1'b1;
                        wre_q  <= 1'b1;
                        wdat_q <= '0;
                        adr_q  <= cnt_q[AW-1:0];
                        cnt_q  <= cnt_d;
                    end
                end
                S_IDLE: begin
                    if (clr_i) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CLEAR;
                    end else if (wb_stb_i) begin
                        ena_q  <= 1'b1;
                        wre_q  <= wb_we_i;
                        adr_q  <= wb_adr_i;
                        wdat_q <= wb_dat_i;
                        if (wb_we_i) begin
                            ack_q   <= 1'b1;
                            state_q <= S_ACK;
                        end else begin
                            state_q <= S_RWAIT;
                        end
                    end
                end
                S_RWAIT: begin
                    ena_q   <= 1'b0;
                    wre_q   <= 1'b0;
                    state_q <= S_RDAT;
                end
                S_RDAT: begin
                    rdat_q  <= ram_dat_i;
                    ack_q   <= 1'b1;
                    state_q <= S_ACK;
                end
                S_ACK: begin
                    ack_q   <= 1'b0;
                    ena_q   <= 1'b0;
                    wre_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb_dat_o  = rdat_q;
    assign wb_ack_o  = ack_q;
    assign busy_o    = busy_q;
    assign ram_ena_o = ena_q;
    assign ram_wre_o = wre_q;
    assign ram_adr_o = adr_q;
    assign ram_dat_o = wdat_q;

endmodule

// File: tb/tb_aemb2_dpsram_port.sv
// Directed-vector bench for aemb2_dpsram_port with a behavioural
// registered-address RAM model on the port side.
module tb_aemb2_dpsram_port;

    logic       clk;
    logic       rst_i;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic [4:0] wb_adr_i;
    logic [1:0] wb_dat_i;
    logic [1:0] wb_dat_o;
    logic       wb_ack_o;
    logic       clr_i;
    logic       busy_o;
    logic       ram_ena_o;
    logic       ram_wre_o;
    logic [4:0] ram_adr_o;
    logic [1:0] ram_dat_o;
    logic [1:0] ram_dat_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    aemb2_dpsram_port #(.AW(5), .DW(2), .CLR_RST(1'b1)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .clr_i    (clr_i),
        .busy_o   (busy_o),
        .ram_ena_o(ram_ena_o),
        .ram_wre_o(ram_wre_o),
        .ram_adr_o(ram_adr_o),
        .ram_dat_o(ram_dat_o),
        .ram_dat_i(ram_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: address captured on enabled edge, data out next cycle.
    logic [1:0] mem [32];
    logic [1:0] rd_q;
    logic       fill;
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 32; i++) mem[i] <= 2'b11;
            rd_q <= 2'b00;
        end else if (ram_ena_o) begin
            if (ram_wre_o) mem[ram_adr_o] <= ram_dat_o;
            rd_q <= mem[ram_adr_o];
        end
    end
    assign ram_dat_i = rd_q;

    typedef struct {
        logic       we;
        logic [4:0] adr;
        logic [1:0] dat;
        logic [1:0] exp;
    } vec_t;

    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_run(input string tag);
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            check({tag, "_issue"}, {busy_o, ram_ena_o, ram_wre_o, ram_adr_o, ram_dat_o},
                  {1'b1, 1'b1, 1'b1, k[4:0], 2'b00});
        end
        @(posedge clk); #1;
        check({tag, "_done"}, {busy_o, ram_ena_o, ram_wre_o}, 3'b000);
    endtask

    task automatic xfer(input logic we, input logic [4:0] adr, input logic [1:0] dat,
                        output logic [1:0] rdat, output int lat,
                        output logic [8:0] first, output logic wre_any,
                        output logic [1:0] post);
        @(negedge clk);
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        lat = 0;
        wre_any = 1'b0;
        first = '0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) first = {ram_ena_o, ram_wre_o, ram_adr_o, ram_dat_o};
            else if (ram_wre_o) wre_any = 1'b1;
        end while (!wb_ack_o && lat < 20);
        rdat = wb_dat_o;
        wb_stb_i = 1'b0;
        @(posedge clk); #1;
        post = {wb_ack_o, ram_ena_o};
    endtask

    logic [1:0] rdat;
    logic [8:0] first;
    logic       wre_any;
    logic [1:0] post;
    int         lat;
    int         n;
    int         m;
    int         bad;

    initial begin
        vt[0] = '{1'b1, 5'd5,  2'b10, 2'b00};
        vt[1] = '{1'b0, 5'd5,  2'b00, 2'b10};
        vt[2] = '{1'b1, 5'd31, 2'b01, 2'b00};
        vt[3] = '{1'b0, 5'd31, 2'b00, 2'b01};
        vt[4] = '{1'b0, 5'd0,  2'b00, 2'b00};
        vt[5] = '{1'b1, 5'd0,  2'b11, 2'b00};
        vt[6] = '{1'b0, 5'd0,  2'b00, 2'b11};
        vt[7] = '{1'b1, 5'd5,  2'b01, 2'b00};
        vt[8] = '{1'b0, 5'd5,  2'b00, 2'b01};
        vt[9] = '{1'b0, 5'd30, 2'b00, 2'b00};

        rst_i = 1'b1;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        clr_i = 1'b0;
        fill = 1'b1;
        #2 rst_i = 1'b0;
        repeat (3) @(negedge clk);
        fill = 1'b0;
        check("reset_vals", {wb_ack_o, wb_dat_o, ram_ena_o, ram_wre_o, ram_adr_o, ram_dat_o, busy_o},
              {1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1});
        @(negedge clk);
        rst_i = 1'b1;
        clear_run("rst_clr");

        for (int i = 0; i < 32; i++) begin
            xfer(1'b0, i[4:0], 2'b00, rdat, lat, first, wre_any, post);
            check("zero_rd_data", rdat, 2'b00);
            check("zero_rd_lat", lat, 3);
        end

        for (int i = 0; i < 10; i++) begin
            xfer(vt[i].we, vt[i].adr, vt[i].dat, rdat, lat, first, wre_any, post);
            check("vec_lat", lat, vt[i].we ? 1 : 3);
            check("vec_issue", first, {1'b1, vt[i].we, vt[i].adr, vt[i].dat});
            check("vec_ack_1cyc", post, 2'b00);
            if (!vt[i].we) begin
                check("vec_rd_data", rdat, vt[i].exp);
                check("vec_rd_nowre", wre_any, 1'b0);
            end
        end

        // Read request held across a requested clear.
        @(negedge clk);
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        wb_stb_i = 1'b1;
        wb_we_i = 1'b0;
        wb_adr_i = 5'd5;
        n = busy_o ? 1 : 0;
        bad = 0;
        while (busy_o && n < 100) begin
            @(posedge clk); #1;
            if (wb_ack_o) bad++;
            if (busy_o) n++;
        end
        check("stb_clr_busy_len", n, 33);
        check("stb_clr_no_ack", bad, 0);
        m = 0;
        while (!wb_ack_o && m < 20) begin
            @(posedge clk); #1;
            m++;
        end
        check("stb_clr_rd_lat", m, 3);
        check("stb_clr_rd_data", wb_dat_o, 2'b00);
        wb_stb_i = 1'b0;
        @(posedge clk); #1;

        // Clear and write strobe in the same idle cycle.
        @(negedge clk);
        clr_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i = 1'b1;
        wb_adr_i = 5'd7;
        wb_dat_i = 2'b10;
        @(posedge clk); #1;
        clr_i = 1'b0;
        check("clr_wr_first", {busy_o, wb_ack_o}, 2'b10);
        n = 0;
        bad = 0;
        m = 0;
        while (busy_o && m < 100) begin
            @(posedge clk); #1;
            m++;
            if (wb_ack_o) bad++;
            if (busy_o && ram_ena_o && ram_wre_o) n++;
        end
        check("clr_wr_nwrites", n, 32);
        check("clr_wr_no_ack", bad, 0);
        m = 0;
        while (!wb_ack_o && m < 20) begin
            @(posedge clk); #1;
            m++;
        end
        check("clr_wr_lat", m, 1);
        wb_stb_i = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 5'd7, 2'b00, rdat, lat, first, wre_any, post);
        check("clr_wr_rdback", rdat, 2'b10);

        // Reset in the middle of a clear.
        @(negedge clk);
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        m = 0;
        while (ram_adr_o != 5'd17 && m < 100) begin
            @(posedge clk); #1;
            m++;
        end
        check("mid_clr_reach17", {busy_o, ram_adr_o}, {1'b1, 5'd17});
        #2 rst_i = 1'b0;
        #1;
        check("async_rst_vals", {wb_ack_o, wb_dat_o, ram_ena_o, ram_wre_o, ram_adr_o, ram_dat_o, busy_o},
              {1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1});
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        clear_run("re_clr");
        xfer(1'b0, 5'd7, 2'b00, rdat, lat, first, wre_any, post);
        check("re_clr_rdback", rdat, 2'b00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
